alu_control_seq: RTL and testbench

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

---
 rtl/alu_control_seq.sv | 129 ++++++++++++
 tb/tb_alu_control_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - ALU selector decode with multi-cycle mul/div sequencing
// Single-cycle ops complete on accept; mul/div hold the pipeline for their latency.
module alu_control_seq #(
  parameter int FUNC_W   = 6,
  parameter int AOP_W    = 4,
  parameter int SEL_W    = 4,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int MULTI_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AOP_W-1:0]  aluop,
  input  logic [FUNC_W-1:0] func,
  input  logic              flush,
  output logic [SEL_W-1:0]  ops,
  output logic              ops_valid,
  output logic              stall,
  output logic              illegal
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [SEL_W-1:0] SEL_NOP = SEL_W'(4'b1101);
  localparam logic [SEL_W-1:0] SEL_ILL = SEL_W'(4'b1111);
  localparam logic [3:0]       MUL_LOAD = 4'(MUL_LAT - 1);
  localparam logic [3:0]       DIV_LOAD = 4'(DIV_LAT - 1);
  localparam bit               MULTI    = (MULTI_EN != 0);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [SEL_W-1:0] ops_q;
  logic             ops_valid_q;
  logic             illegal_q;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_ill;
  logic             dec_mul;
  logic             dec_div;
  logic             dec_multi;
  logic [3:0]       lat_load;

  always_comb begin
    dec_sel = SEL_ILL;
    dec_ill = 1'b1;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (aluop)
      AOP_W'(4'b0000): begin dec_sel = SEL_W'(4'b0010); dec_ill = 1'b0; end
      AOP_W'(4'b0001): begin dec_sel = SEL_W'(4'b0110); dec_ill = 1'b0; end
      AOP_W'(4'b0011): begin dec_sel = SEL_W'(4'b1011); dec_ill = 1'b0; end
      AOP_W'(4'b0100): begin dec_sel = SEL_W'(4'b0000); dec_ill = 1'b0; end
      AOP_W'(4'b0101): begin dec_sel = SEL_W'(4'b0001); dec_ill = 1'b0; end
      AOP_W'(4'b0110): begin dec_sel = SEL_W'(4'b1001); dec_ill = 1'b0; end
      AOP_W'(4'b0111): begin dec_sel = SEL_W'(4'b0111); dec_ill = 1'b0; end
      AOP_W'(4'b1111): begin dec_sel = SEL_W'(4'b1100); dec_ill = 1'b0; end
      AOP_W'(4'b0010): begin
        case (func)
          FUNC_W'(6'b000000): begin dec_sel = SEL_NOP;         dec_ill = 1'b0; end
          FUNC_W'(6'b100100): begin dec_sel = SEL_W'(4'b0000); dec_ill = 1'b0; end
          FUNC_W'(6'b100101): begin dec_sel = SEL_W'(4'b0001); dec_ill = 1'b0; end
          FUNC_W'(6'b100000): begin dec_sel = SEL_W'(4'b0010); dec_ill = 1'b0; end
          FUNC_W'(6'b100111): begin dec_sel = SEL_W'(4'b0100); dec_ill = 1'b0; end
          FUNC_W'(6'b000010): begin dec_sel = SEL_W'(4'b0101); dec_ill = 1'b0; dec_mul = 1'b1; end
          FUNC_W'(6'b100010): begin dec_sel = SEL_W'(4'b0110); dec_ill = 1'b0; end
          FUNC_W'(6'b011010): begin dec_sel = SEL_W'(4'b1000); dec_ill = 1'b0; dec_div = 1'b1; end
          FUNC_W'(6'b101010): begin dec_sel = SEL_W'(4'b1001); dec_ill = 1'b0; end
          default:            begin dec_sel = SEL_ILL;         dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_sel = SEL_ILL; dec_ill = 1'b1; end
    endcase
  end

  assign dec_multi = MULTI && (dec_mul || dec_div);
  assign lat_load  = dec_div ? DIV_LOAD : MUL_LOAD;

  // Flush outranks both a new accept and a pending completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ops_q       <= SEL_NOP;
      ops_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ops_q       <= SEL_NOP;
      ops_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      ops_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ops_q <= dec_sel;
            if (dec_multi) begin
              state_q <= BUSY;
              cnt_q   <= lat_load;
            end else begin
              ops_valid_q <= 1'b1;
              illegal_q   <= dec_ill;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd1) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ops_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign stall     = (state_q == BUSY);
  assign ops       = ops_q;
  assign ops_valid = ops_valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - scoreboard bench for alu_control_seq
// Two instances: default sequencing and MULTI_EN=0 single-cycle mode.
module tb_alu_control_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid, flush, in_ready, ops_valid, stall, illegal;
  logic [3:0] aluop, ops;
  logic [5:0] func;
  logic       in_valid0, flush0, in_ready0, ops_valid0, stall0, illegal0;
  logic [3:0] aluop0, ops0;
  logic [5:0] func0;

  int n_pass  = 0;
  int n_total = 0;
  int n;

  logic [4:0] q1[$];
  logic [4:0] q0[$];
  logic [4:0] e1, e0;

  typedef struct packed {
    logic [3:0] aop;
    logic [5:0] fn;
    logic [3:0] sel;
    logic       ill;
  } vec_t;

  vec_t tbl[16] = '{
    '{4'b0000, 6'b000000, 4'b0010, 1'b0},
    '{4'b0001, 6'b000000, 4'b0110, 1'b0},
    '{4'b0011, 6'b000000, 4'b1011, 1'b0},
    '{4'b0100, 6'b000000, 4'b0000, 1'b0},
    '{4'b0101, 6'b000000, 4'b0001, 1'b0},
    '{4'b0110, 6'b000000, 4'b1001, 1'b0},
    '{4'b0111, 6'b000000, 4'b0111, 1'b0},
    '{4'b1111, 6'b000000, 4'b1100, 1'b0},
    '{4'b0010, 6'b000000, 4'b1101, 1'b0},
    '{4'b0010, 6'b100100, 4'b0000, 1'b0},
    '{4'b0010, 6'b100101, 4'b0001, 1'b0},
    '{4'b0010, 6'b100111, 4'b0100, 1'b0},
    '{4'b0010, 6'b100010, 4'b0110, 1'b0},
    '{4'b0010, 6'b101010, 4'b1001, 1'b0},
    '{4'b1010, 6'b000000, 4'b1111, 1'b1},
    '{4'b0010, 6'b111111, 4'b1111, 1'b1}
  };

  alu_control_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .func(func), .flush(flush), .ops(ops),
    .ops_valid(ops_valid), .stall(stall), .illegal(illegal)
  );

  alu_control_seq #(.MULTI_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .aluop(aluop0), .func(func0), .flush(flush0), .ops(ops0),
    .ops_valid(ops_valid0), .stall(stall0), .illegal(illegal0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every ops_valid pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (ops_valid) begin
      if (q1.size() == 0) chk("unexpected_valid", 32'(ops_valid), 32'(0));
      else begin
        e1 = q1.pop_front();
        chk("sb_ops", 32'(ops), 32'(e1[4:1]));
        chk("sb_illegal", 32'(illegal), 32'(e1[0]));
      end
    end else if (illegal) chk("stray_illegal", 32'(illegal), 32'(0));
    if (ops_valid0) begin
      if (q0.size() == 0) chk("unexpected_valid0", 32'(ops_valid0), 32'(0));
      else begin
        e0 = q0.pop_front();
        chk("sb0_ops", 32'(ops0), 32'(e0[4:1]));
        chk("sb0_illegal", 32'(illegal0), 32'(e0[0]));
      end
    end
    if (stall0) chk("stall0_never", 32'(stall0), 32'(0));
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; aluop = 4'd0; func = 6'd0; flush = 1'b0;
    in_valid0 = 1'b0; aluop0 = 4'd0; func0 = 6'd0; flush0 = 1'b0;
    cyc();
    chk("rst_ops", 32'(ops), 32'(4'b1101));
    chk("rst_valid", 32'(ops_valid), 32'(0));
    chk("rst_illegal", 32'(illegal), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single add
    in_valid = 1'b1; aluop = 4'b0010; func = 6'b100000;
    q1.push_back({4'b0010, 1'b0});
    cyc();
    in_valid = 1'b0;
    chk("add_valid", 32'(ops_valid), 32'(1));
    chk("add_stall", 32'(stall), 32'(0));
    cyc();
    chk("add_pulse_end", 32'(ops_valid), 32'(0));

    // Back-to-back single-cycle decode table
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; aluop = tbl[i].aop; func = tbl[i].fn;
      q1.push_back({tbl[i].sel, tbl[i].ill});
      cyc();
      chk("b2b_valid", 32'(ops_valid), 32'(1));
    end
    in_valid = 1'b0;
    cyc();
    chk("ill_one_cycle_valid", 32'(ops_valid), 32'(0));
    chk("ill_one_cycle_illegal", 32'(illegal), 32'(0));

    // Mul, with an add held by the requester during BUSY
    in_valid = 1'b1; aluop = 4'b0010; func = 6'b000010;
    q1.push_back({4'b0101, 1'b0});
    q1.push_back({4'b0010, 1'b0});
    cyc();
    aluop = 4'b0000; func = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      chk("mul_stall", 32'(stall), 32'(1));
      chk("mul_ready", 32'(in_ready), 32'(0));
      chk("mul_ops_held", 32'(ops), 32'(4'b0101));
      chk("mul_no_valid", 32'(ops_valid), 32'(0));
      cyc();
    end
    chk("mul_done_valid", 32'(ops_valid), 32'(1));
    chk("mul_done_ready", 32'(in_ready), 32'(1));
    chk("mul_done_stall", 32'(stall), 32'(0));
    cyc();
    in_valid = 1'b0;
    chk("held_add_valid", 32'(ops_valid), 32'(1));
    chk("held_add_ops", 32'(ops), 32'(4'b0010));
    cyc();

    // Div flushed in its 3rd BUSY cycle
    in_valid = 1'b1; aluop = 4'b0010; func = 6'b011010;
    cyc();
    in_valid = 1'b0;
    chk("div_stall", 32'(stall), 32'(1));
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_ops", 32'(ops), 32'(4'b1101));
    chk("flush_stall", 32'(stall), 32'(0));
    chk("flush_valid", 32'(ops_valid), 32'(0));
    chk("flush_illegal", 32'(illegal), 32'(0));
    repeat (10) cyc();

    // Flush in IDLE discards a request
    in_valid = 1'b1; aluop = 4'b0000; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_valid", 32'(ops_valid), 32'(0));
    chk("idle_flush_ops", 32'(ops), 32'(4'b1101));
    cyc();

    // Full div latency and hold after completion
    in_valid = 1'b1; aluop = 4'b0010; func = 6'b011010;
    q1.push_back({4'b1000, 1'b0});
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!ops_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("div_latency", 32'(n), 32'(7));
    cyc();
    chk("div_ops_hold", 32'(ops), 32'(4'b1000));
    chk("div_post_valid", 32'(ops_valid), 32'(0));

    // Reset asserted mid-mul
    in_valid = 1'b1; aluop = 4'b0010; func = 6'b000010;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_ops", 32'(ops), 32'(4'b1101));
    chk("arst_stall", 32'(stall), 32'(0));
    chk("arst_ready", 32'(in_ready), 32'(1));
    chk("arst_valid", 32'(ops_valid), 32'(0));
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b1; aluop = 4'b0000; func = 6'b000000;
    q1.push_back({4'b0010, 1'b0});
    cyc();
    in_valid = 1'b0;
    chk("post_rst_ops", 32'(ops), 32'(4'b0010));
    chk("post_rst_valid", 32'(ops_valid), 32'(1));
    repeat (10) cyc();

    // MULTI_EN=0 stream: mul, add, div, sub, slt
    aluop0 = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      in_valid0 = 1'b1;
      case (i)
        0: begin func0 = 6'b000010; q0.push_back({4'b0101, 1'b0}); end
        1: begin func0 = 6'b100000; q0.push_back({4'b0010, 1'b0}); end
        2: begin func0 = 6'b011010; q0.push_back({4'b1000, 1'b0}); end
        3: begin func0 = 6'b100010; q0.push_back({4'b0110, 1'b0}); end
        default: begin func0 = 6'b101010; q0.push_back({4'b1001, 1'b0}); end
      endcase
      cyc();
      chk("single_valid", 32'(ops_valid0), 32'(1));
    end
    in_valid0 = 1'b0;
    cyc();
    chk("single_end", 32'(ops_valid0), 32'(0));
    repeat (3) cyc();

    chk("sb_drained", 32'(q1.size()), 32'(0));
    chk("sb0_drained", 32'(q0.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
